onehot_alu_pipe: RTL and testbench
==================================

ONEHOT_ALU_PIPE -- requirements
Module: onehot_alu_pipe

Interface
REQ-001 SHALL have parameter W, default 4: binary operand width; one-hot width is N = 2**W.
REQ-002 SHALL have parameter ACC_EN, default 1: 1 enables the accumulator opcodes; 0 makes ACC_ADD/ACC_CLR behave as NOP.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-007 SHALL have port a_oh and b_oh, input, N each: one-hot operands; bit k set means value k.
REQ-008 SHALL have port opcode, input, 3: operation select.
REQ-009 SHALL have port out_valid, output, 1: result beat present.
REQ-010 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-011 SHALL have port result_oh, output, N: one-hot result.
REQ-012 SHALL have port result_bin, output, W: binary result for the existing seven-segment decoder.
REQ-013 SHALL have port overflow, output, 1: per-beat overflow flag.
REQ-014 SHALL have port invalid, output, 1: an operand was not exactly one-hot.
REQ-015 SHALL have port ovf_sticky, output, 1: OR of all overflows since reset.

Function
REQ-016 SHALL decode opcodes as: 000 PASS_A, 001 ADD, 010 SUB, 011 MUL, 100 AND, 101 OR, 110 ACC_ADD, 111 ACC_CLR.
REQ-017 SHALL compute in two registered stages: S1 (one-hot to binary, validity check) and S2 (operation, output register); latency from accept to out_valid SHALL be exactly 2 cycles with no stall.
REQ-018 SHALL do all arithmetic mod 2**W. ADD overflows on carry-out; SUB overflows when a<b (result wraps); MUL overflows when any bit of the 2W-bit product above W-1 is set; PASS/AND/OR/ACC_CLR never overflow.
REQ-019 SHALL make ACC_ADD compute acc+a (b ignored), with overflow on carry; acc SHALL update and result SHALL equal the new acc.
REQ-020 SHALL make ACC_CLR set acc to 0 and return result 0.
REQ-021 SHALL treat an operand as invalid when it has zero or more than one bit set; only operands the opcode uses count (a alone for PASS/ACC_*, none for ACC_CLR).
REQ-022 SHALL, on an invalid beat, assert invalid=1, force result_bin=0, result_oh=1, overflow=0, and leave acc unchanged.
REQ-023 SHALL set result_oh = 1 << result_bin on every valid beat.
REQ-024 SHALL stall the pipeline when out_valid && !out_ready: S2 and output ports hold, S1 holds if full, and in_ready = !S1_full || S2 advancing.
REQ-025 SHALL sustain one beat per cycle when out_ready is held high.
REQ-026 SHALL update acc and ovf_sticky only when a beat moves from S1 to S2, exactly once per beat, regardless of stall duration.

Reset
REQ-027 SHALL, while rst=1, clear S1/S2 valid, acc, out_valid, result_bin, result_oh, overflow, invalid and ovf_sticky to 0, and drive in_ready=0.
REQ-028 SHALL discard in-flight beats on reset mid-operation; in_ready SHALL be 1 on the first cycle after rst falls.

Structure
REQ-029 SHALL place the opcode enum and the onehot-width helper function in package onehot_alu_pkg.
REQ-030 SHALL use one sub-module, onehot_encoder (N to W plus valid flag), instantiated for each operand.

Verification (W=4)
REQ-031 Bench SHALL check: a=0x0400, b=0x0004, ADD/SUB/MUL back-to-back -> result_oh 0x1000/0x0100/0x0010, MUL overflow=1, each 2 cycles after accept.
REQ-032 Bench SHALL check: a=0x0004 (2), b=0x0008 (3), SUB -> result_bin=15, result_oh=0x8000, overflow=1, ovf_sticky=1.
REQ-033 Bench SHALL check: a=0x0003, ADD -> invalid=1, result_oh=0x0001, acc unchanged.
REQ-034 Bench SHALL check: ACC_CLR, then ACC_ADD a=0x0800 twice -> results 0, 11, 6; second ACC_ADD overflow=1.
REQ-035 Bench SHALL check: out_ready low 3 cycles with 4 beats offered -> in_ready drops after 2 accepts, outputs hold, no beat lost or duplicated, order preserved.
REQ-036 Bench SHALL check: rst pulse while 2 beats are in flight -> out_valid=0 next cycle, acc=0, and neither beat ever appears.

Source files
------------

// File: rtl/onehot_alu_pkg.sv
// Shared types and helpers for the one-hot ALU pipeline.
package onehot_alu_pkg;

  typedef enum logic [2:0] {
    OpPassA  = 3'b000,
    OpAdd    = 3'b001,
    OpSub    = 3'b010,
    OpMul    = 3'b011,
    OpAnd    = 3'b100,
    OpOr     = 3'b101,
    OpAccAdd = 3'b110,
    OpAccClr = 3'b111
  } opcode_e;

  // One-hot vector width for a W-bit binary value.
  function automatic int unsigned onehot_width(int unsigned w);
    return 32'd1 << w;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// One-hot to binary encoder; valid_o is set only when exactly one bit is set.
module onehot_encoder
  import onehot_alu_pkg::*;
#(
  parameter int unsigned W = 4,
  parameter int unsigned N = onehot_width(W)
) (
  input  logic [N-1:0] oh_i,
  output logic [W-1:0] bin_o,
  output logic         valid_o
);

  logic seen;
  logic multi;

  // OR-ing the indices is exact for a true one-hot input; other inputs are flagged invalid.
  always_comb begin
    bin_o = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (oh_i[k]) begin
        if (seen) multi = 1'b1;
        seen  = 1'b1;
        bin_o = bin_o | W'(k);
      end
    end
    valid_o = seen && !multi;
  end

endmodule

// File: rtl/onehot_alu_pipe.sv
// Two-stage one-hot ALU: S1 decodes/validates operands, S2 computes and holds the result.
module onehot_alu_pipe
  import onehot_alu_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter bit          ACC_EN = 1'b1,
  localparam int unsigned N     = onehot_width(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_oh,
  input  logic [N-1:0] b_oh,
  input  logic [2:0]   opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result_oh,
  output logic [W-1:0] result_bin,
  output logic         overflow,
  output logic         invalid,
  output logic         ovf_sticky
);

  localparam logic [N-1:0] OhOne = {{(N-1){1'b0}}, 1'b1};

  logic [W-1:0] a_bin, b_bin;
  logic         a_ok, b_ok;

  onehot_encoder #(.W(W), .N(N)) u_enc_a (
    .oh_i    (a_oh),
    .bin_o   (a_bin),
    .valid_o (a_ok)
  );

  onehot_encoder #(.W(W), .N(N)) u_enc_b (
    .oh_i    (b_oh),
    .bin_o   (b_bin),
    .valid_o (b_ok)
  );

  opcode_e      op_in;
  logic         use_a, use_b, in_bad;
  logic         accept, s2_adv;

  logic         s1_valid_q, s1_valid_d;
  opcode_e      s1_op_q, s1_op_d;
  logic [W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic         s1_bad_q, s1_bad_d;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] res_bin_q, res_bin_d;
  logic [N-1:0] res_oh_q, res_oh_d;
  logic         ovf_q, ovf_d;
  logic         inv_q, inv_d;
  logic [W-1:0] acc_q, acc_d;
  logic         sticky_q, sticky_d;

  logic [W:0]     sum, acc_sum;
  logic [W-1:0]   diff;
  logic [2*W-1:0] prod;
  logic [W-1:0]   alu_bin, acc_nxt;
  logic           alu_ovf;

  assign op_in = opcode_e'(opcode);

  // Only operands the opcode actually reads are checked for one-hotness.
  always_comb begin
    use_a = 1'b1;
    use_b = 1'b0;
    case (op_in)
      OpAdd, OpSub, OpMul, OpAnd, OpOr: use_b = 1'b1;
      OpAccAdd: use_a = ACC_EN;
      OpAccClr: use_a = 1'b0;
      default: ;
    endcase
    in_bad = (use_a && !a_ok) || (use_b && !b_ok);
  end

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !rst && (!s1_valid_q || s2_adv);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    acc_sum = {1'b0, acc_q} + {1'b0, s1_a_q};
    diff    = s1_a_q - s1_b_q;
    prod    = {{W{1'b0}}, s1_a_q} * {{W{1'b0}}, s1_b_q};
    alu_bin = '0;
    alu_ovf = 1'b0;
    acc_nxt = acc_q;
    case (s1_op_q)
      OpPassA: alu_bin = s1_a_q;
      OpAdd: begin
        alu_bin = sum[W-1:0];
        alu_ovf = sum[W];
      end
      OpSub: begin
        alu_bin = diff;
        alu_ovf = s1_a_q < s1_b_q;
      end
      OpMul: begin
        alu_bin = prod[W-1:0];
        alu_ovf = |prod[2*W-1:W];
      end
      OpAnd: alu_bin = s1_a_q & s1_b_q;
      OpOr:  alu_bin = s1_a_q | s1_b_q;
      OpAccAdd: begin
        if (ACC_EN) begin
          alu_bin = acc_sum[W-1:0];
          alu_ovf = acc_sum[W];
          acc_nxt = acc_sum[W-1:0];
        end
      end
      OpAccClr: begin
        if (ACC_EN) acc_nxt = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_bad_d    = s1_bad_q;
    out_valid_d = out_valid_q;
    res_bin_d   = res_bin_q;
    res_oh_d    = res_oh_q;
    ovf_d       = ovf_q;
    inv_d       = inv_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op_in;
      s1_a_d     = a_bin;
      s1_b_d     = b_bin;
      s1_bad_d   = in_bad;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    // acc and sticky change only on the S1->S2 transfer, so a stall never re-applies a beat.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (s1_bad_q) begin
          res_bin_d = '0;
          res_oh_d  = OhOne;
          ovf_d     = 1'b0;
          inv_d     = 1'b1;
        end else begin
          res_bin_d = alu_bin;
          res_oh_d  = OhOne << alu_bin;
          ovf_d     = alu_ovf;
          inv_d     = 1'b0;
          acc_d     = acc_nxt;
          sticky_d  = sticky_q | alu_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OpPassA;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_bad_q    <= 1'b0;
      out_valid_q <= 1'b0;
      res_bin_q   <= '0;
      res_oh_q    <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_bad_q    <= s1_bad_d;
      out_valid_q <= out_valid_d;
      res_bin_q   <= res_bin_d;
      res_oh_q    <= res_oh_d;
      ovf_q       <= ovf_d;
      inv_q       <= inv_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result_bin = res_bin_q;
  assign result_oh  = res_oh_q;
  assign overflow   = ovf_q;
  assign invalid    = inv_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_onehot_alu_pipe.sv
// Scoreboard bench for onehot_alu_pipe (W=4): driver pushes expectations, monitor pops on handshake.
module tb_onehot_alu_pipe;

  localparam int unsigned W = 4;
  localparam int unsigned N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a_oh = '0;
  logic [N-1:0] b_oh = '0;
  logic [2:0]   opcode = 3'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] result_oh;
  logic [W-1:0] result_bin;
  logic         overflow;
  logic         invalid;
  logic         ovf_sticky;

  onehot_alu_pipe #(.W(W), .ACC_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_oh       (a_oh),
    .b_oh       (b_oh),
    .opcode     (opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_oh  (result_oh),
    .result_bin (result_bin),
    .overflow   (overflow),
    .invalid    (invalid),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  bin;
    logic [15:0] oh;
    logic        ovf;
    logic        inv;
    logic        sticky;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   last_waits = 0;
  bit   quiet = 1'b0;
  bit   lat_on = 1'b1;
  logic exp_sticky = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // out_ready is held low for stall_cnt negedge-aligned cycles when requested.
  initial begin
    forever begin
      @(negedge clk);
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: compares the queue head every cycle a beat is presented, pops on handshake.
  initial begin
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (quiet) begin
        seen = 1'b0;
      end else if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          e = q[0];
          if (!seen && e.chk_lat) chk({e.tag, " latency"}, 32'(cyc - e.acc_cyc), 32'd2);
          seen = 1'b1;
          chk({e.tag, " result_bin"}, 32'(result_bin), 32'(e.bin));
          chk({e.tag, " result_oh"}, 32'(result_oh), 32'(e.oh));
          chk({e.tag, " overflow"}, 32'(overflow), 32'(e.ovf));
          chk({e.tag, " invalid"}, 32'(invalid), 32'(e.inv));
          chk({e.tag, " ovf_sticky"}, 32'(ovf_sticky), 32'(e.sticky));
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input string tag, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] bin, input logic [15:0] oh,
                      input logic ovf, input logic inv);
    exp_t e;
    int   waits;
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = op;
    a_oh     = a;
    b_oh     = b;
    #2;
    while (in_ready !== 1'b1) begin
      waits++;
      if (waits > 40) begin
        $display("FAIL %s accept_timeout: actual in_ready=%b required 1", tag, in_ready);
        $fatal(1, "accept timeout");
      end
      @(negedge clk);
      #2;
    end
    if (!quiet) begin
      exp_sticky = exp_sticky | ovf;
      e.tag     = tag;
      e.bin     = bin;
      e.oh      = oh;
      e.ovf     = ovf;
      e.inv     = inv;
      e.sticky  = exp_sticky;
      e.acc_cyc = cyc;
      e.chk_lat = lat_on;
      q.push_back(e);
    end
    last_waits = waits;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w[4];
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst result_oh", 32'(result_oh), 32'd0);
    chk("rst result_bin", 32'(result_bin), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst invalid", 32'(invalid), 32'd0);
    chk("rst ovf_sticky", 32'(ovf_sticky), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst in_ready", 32'(in_ready), 32'd1);

    // Back-to-back arithmetic: a=10, b=2
    send("add",  3'b001, 16'h0400, 16'h0004, 4'd12, 16'h1000, 1'b0, 1'b0);
    send("sub",  3'b010, 16'h0400, 16'h0004, 4'd8,  16'h0100, 1'b0, 1'b0);
    send("mul",  3'b011, 16'h0400, 16'h0004, 4'd4,  16'h0010, 1'b1, 1'b0);
    send("subw", 3'b010, 16'h0004, 16'h0008, 4'd15, 16'h8000, 1'b1, 1'b0);
    // Accumulator
    send("aclr", 3'b111, 16'h0000, 16'h0000, 4'd0,  16'h0001, 1'b0, 1'b0);
    send("acc1", 3'b110, 16'h0800, 16'h0000, 4'd11, 16'h0800, 1'b0, 1'b0);
    send("acc2", 3'b110, 16'h0800, 16'h0000, 4'd6,  16'h0040, 1'b1, 1'b0);
    // Invalid operands leave acc at 6
    send("inv_add", 3'b001, 16'h0003, 16'h0004, 4'd0, 16'h0001, 1'b0, 1'b1);
    send("inv_acc", 3'b110, 16'h0000, 16'h0000, 4'd0, 16'h0001, 1'b0, 1'b1);
    send("acc3",    3'b110, 16'h0002, 16'h0000, 4'd7, 16'h0080, 1'b0, 1'b0);
    // Logic ops and edge cases
    send("pass",  3'b000, 16'h0020, 16'h0000, 4'd5, 16'h0020, 1'b0, 1'b0);
    send("and",   3'b100, 16'h0040, 16'h0008, 4'd2, 16'h0004, 1'b0, 1'b0);
    send("or",    3'b101, 16'h0040, 16'h0008, 4'd7, 16'h0080, 1'b0, 1'b0);
    send("inv_b", 3'b100, 16'h0040, 16'h0000, 4'd0, 16'h0001, 1'b0, 1'b1);
    send("addc",  3'b001, 16'h8000, 16'h0002, 4'd0, 16'h0001, 1'b1, 1'b0);
    drain();

    // Backpressure: out_ready low for 3 cycles while 4 beats are offered
    @(posedge clk);
    #1;
    lat_on = 1'b0;
    stall_cnt = 3;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] v;
      logic [3:0]  vb;
      v  = 16'h0002 << i;
      vb = 4'(i + 1);
      send($sformatf("stall%0d", i), 3'b000, v, 16'h0000, vb, v, 1'b0, 1'b0);
      w[i] = last_waits;
    end
    chk("stall waits0", 32'(w[0]), 32'd0);
    chk("stall waits1", 32'(w[1]), 32'd0);
    chk("stall waits2", 32'(w[2]), 32'd1);
    chk("stall waits3", 32'(w[3]), 32'd0);
    drain();
    lat_on = 1'b1;

    // Reset with two beats in flight; neither may ever emerge
    quiet = 1'b1;
    send("ghost0", 3'b110, 16'h0008, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0);
    send("ghost1", 3'b110, 16'h0008, 16'h0000, 4'd0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    chk("midrst ovf_sticky", 32'(ovf_sticky), 32'd0);
    rst = 1'b0;
    exp_sticky = 1'b0;
    #1;
    chk("midrst_release in_ready", 32'(in_ready), 32'd1);
    quiet = 1'b0;
    send("acc_after_rst", 3'b110, 16'h0002, 16'h0000, 4'd1,  16'h0002, 1'b0, 1'b0);
    send("sub_after_rst", 3'b010, 16'h0001, 16'h0002, 4'd15, 16'h8000, 1'b1, 1'b0);
    send("acc_wrap",      3'b110, 16'h8000, 16'h0000, 4'd0,  16'h0001, 1'b1, 1'b0);
    drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
